cmp_rr_scheduler: RTL
=====================

// Module: cmp_rr_scheduler
// PURPOSE
//   Shares one 16-bit signed magnitude comparator (g/l/e) among NREQ requesters.
//   - Round-robin arbitration picks one pending request per cycle.
//   - The result is registered with the requester ID.
//   - The result is held in a one-entry output stage with valid/ready backpressure.
//   - Sits between compare-issuing units (sort/min-max engines) and the shared comparator.
// PARAMETERS
//   NREQ   4    number of requesters (2..8)
//   W      16   operand width, two's complement
//   IDW    2    requester ID width, equal to clog2(NREQ)
// PORTS
//   clk        in   1         single clock; all logic on rising edge
//   rst_n      in   1         reset, synchronous and active-low
//   req_valid  in   NREQ      bit i: requester i has an operand pair pending
//   req_a      in   NREQ*W    operand A of requester i, in bits [i*W +: W]
//   req_b      in   NREQ*W    operand B of requester i, in bits [i*W +: W]
//   req_ready  out  NREQ      one-hot grant; transfer on req_valid[i] & req_ready[i]
//   rsp_valid  out  1         result stage holds a valid result
//   rsp_ready  in   1         consumer accepts the result
//   rsp_id     out  IDW       requester index of the held result
//   rsp_g      out  1         A > B (signed)
//   rsp_l      out  1         A < B (signed)
//   rsp_e      out  1         A == B
//   cmp_count  out  16        count of completed compares (rsp handshakes); wraps
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge):
//     - rsp_valid, rsp_id, rsp_g, rsp_l and rsp_e all go to 0.
//     - cmp_count goes to 0.
//     - The round-robin pointer goes to 0, so requester 0 has highest priority.
//     - req_ready is 0 while rst_n=0.
//   Reset mid-operation:
//     - A held result is discarded.
//     - No response is produced for a request whose handshake coincides with the reset edge.
//   FSM, 2 states:
//     EMPTY: rsp_valid=0.
//       - A grant moves to FULL.
//     FULL: rsp_valid=1.
//       - rsp_ready=1 with a new grant: stay in FULL and load the new result (back-to-back).
//       - rsp_ready=1 with no grant: go to EMPTY.
//       - rsp_ready=0: hold. rsp_* must not change.
//   Grant condition:
//     - Grant is allowed when state==EMPTY, or when state==FULL and rsp_ready=1.
//     - req_ready is combinational from req_valid, the pointer and the stage state.
//     - At most one req_ready bit is high. A bit is high only where req_valid is high.
//   Arbitration:
//     - Search starts at the pointer and moves upward, wrapping modulo NREQ.
//     - The first requester with req_valid=1 wins.
//     - After a grant to requester k, the pointer becomes (k+1) mod NREQ.
//     - The pointer is unchanged when there is no grant.
//   Latency:
//     - Request granted in cycle N: the result appears with rsp_valid=1 in cycle N+1.
//     - Sustained throughput is 1 compare per cycle while rsp_ready=1.
//   Compare rules:
//     - Operands are two's complement W bits.
//     - Exactly one of g/l/e is 1 whenever rsp_valid=1.
//     - When signs differ, the negative operand is smaller.
//     - When signs match, the operands are compared unsigned.
//     - Examples: 16'h8000 < 16'h7FFF, and 16'hFFFF (-1) < 16'h0000.
//   Handshake and counter:
//     - Requesters must hold req_a, req_b and req_valid stable until their req_ready.
//     - Operands are sampled only on the grant cycle.
//     - cmp_count increments on each rsp_valid & rsp_ready.
//     - cmp_count wraps from 16'hFFFF to 0.
//   Simultaneous events:
//     - A drain and a load in the same cycle do not change cmp_count except for the drain.
//     - rsp_valid stays high across a back-to-back drain and load.
// TESTING
//   1. Reset behaviour:
//      - Stimulus: assert rst_n=0 for 2 cycles with all req_valid=1.
//      - Required: req_ready=0, rsp_valid=0, cmp_count=0.
//      - After release, the first grant goes to requester 0.
//   2. Signed corner cases, single requester 0 with rsp_ready=1:
//      - (16'h8000, 16'h7FFF) gives l=1.
//      - (16'hFFFF, 16'h0000) gives l=1.
//      - (16'h1234, 16'h1234) gives e=1.
//      - (16'h0001, 16'hFFFE) gives g=1.
//      - Each result appears 1 cycle after its grant.
//   3. Round-robin:
//      - Stimulus: all 4 req_valid=1 continuously, rsp_ready=1.
//      - Required: grant order 0,1,2,3,0,1 with rsp_id matching, and 1 result per cycle.
//   4. Backpressure:
//      - Stimulus: result held with rsp_ready=0 for 5 cycles.
//      - Required: rsp_* stay stable and all req_ready=0.
//      - When rsp_ready rises, the next grant happens in that same cycle.
//   5. Mid-stream reset and counter wrap:
//      - Drive rst_n=0 while in FULL. Required: rsp_valid=0 on the next cycle.
//      - Separately, run 65536 handshakes. Required: cmp_count returns to 0.

Source files
------------

// File: rtl/cmp_rr_scheduler_if.sv
// Request/response bundle between compare issuers and the shared comparator scheduler.
interface cmp_rr_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_g;
  logic              rsp_l;
  logic              rsp_e;
  logic [15:0]       cmp_count;

  // Requesters plus result consumer.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e, cmp_count
  );

  // The scheduler itself.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e, cmp_count
  );
endinterface

// File: rtl/cmp_rr_scheduler.sv
// Round-robin scheduler sharing one signed magnitude comparator among NREQ requesters.
// One-entry registered result stage with valid/ready backpressure.
module cmp_rr_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16,
  parameter int unsigned IDW  = 2
) (
  input logic               clk,
  input logic               rst_n,
  cmp_rr_scheduler_if.slave bus
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_g_q, rsp_g_d;
  logic            rsp_l_q, rsp_l_d;
  logic            rsp_e_q, rsp_e_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand_idx;
  logic            grant_ok;
  logic            grant;
  logic [NREQ-1:0] req_ready;
  logic [W-1:0]    op_a, op_b;
  logic            cmp_g, cmp_l, cmp_e;
  logic            rsp_fire;

  // A new grant may load the stage when it is empty or being drained this cycle.
  assign grant_ok = rst_n && ((state_q == StEmpty) || bus.rsp_ready);
  assign grant    = grant_ok && gnt_found;
  assign rsp_fire = (state_q == StFull) && bus.rsp_ready;

  // Round-robin search: first pending requester at or above the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand_idx = IDW'((32'(ptr_q) + off) % NREQ);
      if (!gnt_found && bus.req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // One-hot grant, only ever on a bit whose req_valid is high.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign op_a = bus.req_a[32'(gnt_idx) * W +: W];
  assign op_b = bus.req_b[32'(gnt_idx) * W +: W];

  // Signed compare: differing signs mean the negative operand is smaller,
  // matching signs reduce to an unsigned compare.
  always_comb begin
    cmp_e = (op_a == op_b);
    if (op_a[W-1] != op_b[W-1]) begin
      cmp_l = op_a[W-1];
    end else begin
      cmp_l = (op_a < op_b);
    end
    cmp_g = !cmp_e && !cmp_l;
  end

  // Result-stage FSM and next-state for pointer, result and counter.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rsp_id_d = rsp_id_q;
    rsp_g_d  = rsp_g_q;
    rsp_l_d  = rsp_l_q;
    rsp_e_d  = rsp_e_q;
    cnt_d    = cnt_q + 16'(rsp_fire);

    unique case (state_q)
      StEmpty: begin
        if (grant) state_d = StFull;
      end
      StFull: begin
        if (bus.rsp_ready) state_d = grant ? StFull : StEmpty;
      end
    endcase

    if (grant) begin
      ptr_d    = IDW'((32'(gnt_idx) + 1) % NREQ);
      rsp_id_d = gnt_idx;
      rsp_g_d  = cmp_g;
      rsp_l_d  = cmp_l;
      rsp_e_d  = cmp_e;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      ptr_q    <= '0;
      rsp_id_q <= '0;
      rsp_g_q  <= 1'b0;
      rsp_l_q  <= 1'b0;
      rsp_e_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
      rsp_g_q  <= rsp_g_d;
      rsp_l_q  <= rsp_l_d;
      rsp_e_q  <= rsp_e_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == StFull);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_g     = rsp_g_q;
  assign bus.rsp_l     = rsp_l_q;
  assign bus.rsp_e     = rsp_e_q;
  assign bus.cmp_count = cnt_q;

endmodule
